attack_fsm: RTL and testbench

ATTACK_FSM -- requirements
Module: attack_fsm

---
 rtl/attack_fsm.sv | 116 +++++++++++
 tb/tb_attack_fsm.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/attack_fsm.sv
// attack_fsm: frame-timed attack sequencer (startup/active/recovery, aerial landing lag).
// Define JAB_COMBO_EN to let a press during jab ACTIVE/RECOVERY chain into jab2.
module attack_fsm #(
    parameter int LANDING_LAG = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       grounded,
    input  logic       btn_atk,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       hit_stun_active,
    output logic       attack_active,
    output logic       hitbox_active,
    output logic [3:0] atk_anim
);
    localparam int CW = (LANDING_LAG > 15) ? $clog2(LANDING_LAG + 1) : 4;

    typedef enum logic [2:0] {IDLE, STARTUP, ACTIVE, RECOVERY, LANDING} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    move, move_n, sel, anim_n;
    logic          pending, pending_n, btn_q, rise, aerial, last, combo_ok, aa_n, hb_n;

    function automatic logic [CW-1:0] phase_len(input logic [3:0] m, input state_t p);
        logic [3:0] s, a, r;
        case (m)
            4'd1:    {s, a, r} = {4'd3, 4'd2, 4'd6};
            4'd2:    {s, a, r} = {4'd5, 4'd3, 4'd10};
            4'd3:    {s, a, r} = {4'd4, 4'd4, 4'd8};
            4'd4:    {s, a, r} = {4'd3, 4'd3, 4'd7};
            4'd9:    {s, a, r} = {4'd2, 4'd3, 4'd10};
            default: {s, a, r} = {4'd5, 4'd4, 4'd12};
        endcase
        return CW'(p == STARTUP ? s : p == ACTIVE ? a : r);
    endfunction

    assign rise   = btn_atk & ~btn_q;
    assign aerial = move >= 4'd5 && move <= 4'd8;
    assign last   = cnt <= CW'(1);
    assign sel    = grounded ? (btn_up ? 4'd3 : btn_down ? 4'd4 : (btn_left | btn_right) ? 4'd2 : 4'd1)
                             : (btn_up ? 4'd7 : btn_down ? 4'd8 : (btn_left | btn_right) ? 4'd6 : 4'd5);

`ifdef JAB_COMBO_EN
    assign combo_ok = move == 4'd1 && (state == ACTIVE || state == RECOVERY);
`else
    assign combo_ok = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        move_n    = move;
        pending_n = pending | (rise & (state == IDLE || combo_ok));
        if (hit_stun_active) begin
            state_n   = IDLE;
            cnt_n     = '0;
            move_n    = 4'd0;
            pending_n = 1'b0;
        end else if (frame_tick) begin
            if (state == IDLE) begin
                if (pending) begin
                    state_n   = STARTUP;
                    move_n    = sel;
                    cnt_n     = phase_len(sel, STARTUP);
                    pending_n = 1'b0;
                end
            end else if (aerial && grounded) begin
                // move is cleared so LANDING no longer counts as an aerial
                state_n = (LANDING_LAG == 0) ? IDLE : LANDING;
                cnt_n   = CW'(LANDING_LAG);
                move_n  = 4'd0;
            end else if (combo_ok && pending) begin
                state_n   = STARTUP;
                move_n    = 4'd9;
                cnt_n     = phase_len(4'd9, STARTUP);
                pending_n = 1'b0;
            end else if (!last) begin
                cnt_n = cnt - CW'(1);
            end else begin
                state_n = state == STARTUP ? ACTIVE : state == ACTIVE ? RECOVERY : IDLE;
                cnt_n   = state_n == IDLE ? '0 : phase_len(move, state_n);
                move_n  = state_n == IDLE ? 4'd0 : move;
            end
        end
        aa_n   = state_n != IDLE;
        hb_n   = state_n == ACTIVE;
        anim_n = state_n == IDLE ? 4'd0 : state_n == LANDING ? 4'd10 : move_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            move          <= 4'd0;
            pending       <= 1'b0;
            btn_q         <= 1'b0;
            attack_active <= 1'b0;
            hitbox_active <= 1'b0;
            atk_anim      <= 4'd0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            move          <= move_n;
            pending       <= pending_n;
            btn_q         <= btn_atk;
            attack_active <= aa_n;
            hitbox_active <= hb_n;
            atk_anim      <= anim_n;
        end
    end
endmodule

// File: tb/tb_attack_fsm.sv
// tb_attack_fsm: directed scenarios; expected output changes are queued and checked by a monitor.
module tb_attack_fsm;
    logic clk = 0, rst = 1, frame_tick = 0, grounded = 0, btn_atk = 0;
    logic btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0, hit_stun_active = 0;
    logic attack_active, hitbox_active;
    logic [3:0] atk_anim;

    typedef struct {logic [5:0] v; int d;} exp_t;
    exp_t q[$];
    exp_t e;
    int total = 0, bad = 0, ticks = 0, last_ticks = 0;
    logic [5:0] prev = 6'd0, cur;

    always #5 clk = ~clk;

    attack_fsm dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .grounded(grounded),
        .btn_atk(btn_atk), .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .hit_stun_active(hit_stun_active),
        .attack_active(attack_active), .hitbox_active(hitbox_active), .atk_anim(atk_anim)
    );

    // Each output change pops one entry: {attack_active, hitbox_active, atk_anim} and ticks since previous change (-1 = any)
    always @(negedge clk) begin
        cur = {attack_active, hitbox_active, atk_anim};
        if (cur !== prev) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_change: got out=%h, none expected", cur);
            end else begin
                e = q.pop_front();
                if (cur !== e.v || (e.d >= 0 && ticks - last_ticks != e.d)) begin
                    bad++;
                    $display("FAIL scoreboard: got out=%h after %0d ticks, want out=%h after %0d ticks",
                             cur, ticks - last_ticks, e.v, e.d);
                end
            end
            prev = cur;
            last_ticks = ticks;
        end
    end

    function automatic void check(input string name, input logic [5:0] act, input logic [5:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endfunction

    task automatic want(input logic aa, input logic hb, input logic [3:0] an, input int d);
        q.push_back('{v: {aa, hb, an}, d: d});
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            frame_tick = 1;
            @(posedge clk); #2;
            frame_tick = 0;
            ticks++;
            @(posedge clk); #2;
        end
    endtask

    task automatic press;
        btn_atk = 1;
        @(posedge clk); #2;
        btn_atk = 0;
        @(posedge clk); #2;
    endtask

    task automatic dirs(input logic u, input logic d, input logic l, input logic r);
        {btn_up, btn_down, btn_left, btn_right} = {u, d, l, r};
    endtask

    task automatic hit_pulse;
        hit_stun_active = 1;
        @(posedge clk); #1;
        check("hitstun_next_clk", {attack_active, hitbox_active, atk_anim}, 6'd0);
        #1;
        hit_stun_active = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check("reset_state", {attack_active, hitbox_active, atk_anim}, 6'd0);
        rst = 0;
        @(posedge clk); #2;
        grounded = 1;
        tick(2);
        // grounded neutral jab: 3/2/6
        press;
        want(1, 0, 1, -1); want(1, 1, 1, 3); want(1, 0, 1, 2); want(0, 0, 0, 6);
        tick(12); tick(2);
        // ftilt, grounded dropped mid-move has no effect
        dirs(0, 0, 1, 0);
        press;
        want(1, 0, 2, -1); want(1, 1, 2, 5); want(1, 0, 2, 3); want(0, 0, 0, 10);
        tick(3); grounded = 0; tick(16);
        grounded = 1;
        // dtilt 3/3/7
        dirs(0, 1, 0, 0);
        press;
        want(1, 0, 4, -1); want(1, 1, 4, 3); want(1, 0, 4, 3); want(0, 0, 0, 7);
        tick(14);
        // up beats down: utilt 4/4/8
        dirs(1, 1, 1, 0);
        press;
        want(1, 0, 3, -1); want(1, 1, 3, 4); want(1, 0, 3, 4); want(0, 0, 0, 8);
        tick(17);
        // airborne nair completes without landing
        grounded = 0;
        dirs(0, 0, 0, 0);
        press;
        want(1, 0, 5, -1); want(1, 1, 5, 5); want(1, 0, 5, 4); want(0, 0, 0, 12);
        tick(22);
        // fair lands during STARTUP
        dirs(0, 0, 1, 0);
        press;
        want(1, 0, 6, -1); want(1, 0, 10, 3); want(0, 0, 0, 4);
        tick(1); tick(2); grounded = 1; tick(1); tick(4);
        // uair lands during ACTIVE
        grounded = 0;
        dirs(1, 0, 0, 0);
        press;
        want(1, 0, 7, -1); want(1, 1, 7, 5); want(1, 0, 10, 2); want(0, 0, 0, 4);
        tick(1); tick(5); tick(1); grounded = 1; tick(1); tick(4);
        // dair lands during RECOVERY
        grounded = 0;
        dirs(0, 1, 0, 0);
        press;
        want(1, 0, 8, -1); want(1, 1, 8, 5); want(1, 0, 8, 4); want(1, 0, 10, 4); want(0, 0, 0, 4);
        tick(1); tick(5); tick(4); tick(3); grounded = 1; tick(1); tick(4);
        // hit stun during utilt STARTUP
        dirs(1, 0, 0, 0);
        press;
        want(1, 0, 3, -1); want(0, 0, 0, 2);
        tick(1); tick(2);
        hit_pulse;
        tick(2);
        // hit stun discards a pending press
        press;
        hit_pulse;
        tick(3);
        // fresh press after hit stun
        press;
        want(1, 0, 3, -1); want(1, 1, 3, 4); want(1, 0, 3, 4); want(0, 0, 0, 8);
        tick(17);
        // async reset mid-dtilt ACTIVE
        dirs(0, 1, 0, 0);
        press;
        want(1, 0, 4, -1); want(1, 1, 4, 3); want(0, 0, 0, 0);
        tick(1); tick(3);
        rst = 1;
        #1;
        check("async_reset", {attack_active, hitbox_active, atk_anim}, 6'd0);
        @(posedge clk); #2;
        rst = 0;
        @(posedge clk); #2;
        tick(15);
        // press during jab RECOVERY
        dirs(0, 0, 0, 0);
        press;
        want(1, 0, 1, -1); want(1, 1, 1, 3); want(1, 0, 1, 2);
        tick(1); tick(3); tick(2); tick(2);
        press;
`ifdef JAB_COMBO_EN
        want(1, 0, 9, 3); want(1, 1, 9, 2); want(1, 0, 9, 3); want(0, 0, 0, 10);
        tick(1); tick(2); tick(3); tick(10); tick(2);
`else
        want(0, 0, 0, 6);
        tick(4); tick(3);
`endif
        repeat (3) @(posedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
